// File: rtl/fifo_idx_alloc_if.sv
// Handshake bundle between the free-index allocator and its writer/reader clients.
// master = client side (requests), slave = allocator side (grants and status).
interface fifo_idx_alloc_if #(
    parameter int PTR_SZ = 2
);
    logic              alloc_req;
    logic              alloc_avail;
    logic [PTR_SZ-1:0] alloc_idx;
    logic              free_req;
    logic [PTR_SZ-1:0] free_idx;
    logic              ready;
    logic [PTR_SZ:0]   free_cnt;
    logic              err;

    modport master (
        output alloc_req, free_req, free_idx,
        input  alloc_avail, alloc_idx, ready, free_cnt, err
    );

    modport slave (
        input  alloc_req, free_req, free_idx,
        output alloc_avail, alloc_idx, ready, free_cnt, err
    );
endinterface

// File: rtl/fifo_idx_alloc.sv
// Circular free list of buffer slot indices: pops to writers, pushes from readers.
// Head visible combinationally, pop/push commit at the edge; full pushes dropped.
// Optional IDX_ALLOC_CHECK_EN adds an ownership vector and a sticky err flag.
module fifo_idx_alloc #(
    parameter int DEPTH  = 4,
    parameter int PTR_SZ = 2
) (
    input  logic             clk,
    input  logic             rst,
    fifo_idx_alloc_if.slave  bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [PTR_SZ-1:0] LAST = PTR_SZ'(DEPTH - 1);
    localparam logic [PTR_SZ:0]   FULL = (PTR_SZ + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [PTR_SZ-1:0] mem_q [DEPTH];
    logic [PTR_SZ-1:0] mem_d [DEPTH];
    logic [PTR_SZ-1:0] hd_q, hd_d, tl_q, tl_d, init_q, init_d;
    logic [PTR_SZ:0]   cnt_q, cnt_d;
    logic [PTR_SZ-1:0] head_idx;
    logic              run, avail, pop, push, full, push_ok;

    function automatic logic [PTR_SZ-1:0] ptr_inc(input logic [PTR_SZ-1:0] p);
        return (p == LAST) ? '0 : p + PTR_SZ'(1);
    endfunction

    // Mux by compare so a PTR_SZ-wide pointer can address a DEPTH-entry array of any size.
    always_comb begin
        head_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (hd_q == PTR_SZ'(i)) head_idx = mem_q[i];
    end

    assign run   = (state_q == RUN);
    assign avail = run && (cnt_q != '0);
    assign pop   = bus.alloc_req && avail;
    assign full  = (cnt_q == FULL);
    assign push  = run && bus.free_req && push_ok;

`ifdef IDX_ALLOC_CHECK_EN
    logic [DEPTH-1:0] own_q, own_d;
    logic             err_q, err_d, bad_rng, owned;

    always_comb begin
        bad_rng = ({1'b0, bus.free_idx} >= FULL);
        owned   = 1'b0;
        own_d   = own_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.free_idx == PTR_SZ'(i)) owned = own_q[i];
            if (pop && head_idx == PTR_SZ'(i)) own_d[i] = 1'b1;
            if (push && bus.free_idx == PTR_SZ'(i)) own_d[i] = 1'b0;
        end
        push_ok = !full && !bad_rng && owned;
        err_d   = err_q | (bus.free_req && (!run || !push_ok));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q <= '0;
            err_q <= 1'b0;
        end else begin
            own_q <= own_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign push_ok = !full;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        hd_d    = hd_q;
        tl_d    = tl_q;
        init_d  = init_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                for (int i = 0; i < DEPTH; i++)
                    if (init_q == PTR_SZ'(i)) mem_d[i] = init_q;
                init_d = ptr_inc(init_q);
                if (init_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = FULL;
                    hd_d    = '0;
                    tl_d    = '0;
                end
            end
            RUN: begin
                if (pop) hd_d = ptr_inc(hd_q);
                if (push) begin
                    for (int i = 0; i < DEPTH; i++)
                        if (tl_q == PTR_SZ'(i)) mem_d[i] = bus.free_idx;
                    tl_d = ptr_inc(tl_q);
                end
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + (PTR_SZ + 1)'(1);
                    2'b01:   cnt_d = cnt_q - (PTR_SZ + 1)'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            hd_q    <= '0;
            tl_q    <= '0;
            init_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            hd_q    <= hd_d;
            tl_q    <= tl_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready       = run;
    assign bus.alloc_avail = avail;
    assign bus.alloc_idx   = head_idx;
    assign bus.free_cnt    = cnt_q;
endmodule

// File: doc/fifo_idx_alloc.md
# fifo_idx_alloc

Free-index allocator for the router's buffer pool. It holds a circular free list of buffer slot indices and hands them out to the writer side. It takes them back from the reader side when a slot is drained. It is the producer/consumer counterpart of `fifo_idx_map`: `fifo_idx_map` stores which physical slot sits at each logical position, and `fifo_idx_alloc` decides which physical slots are free to be placed there.

## Interface
Parameters:
- `DEPTH`, 4: number of buffer slots managed; must satisfy DEPTH <= 2^PTR_SZ.
- `PTR_SZ`, 2: width of a slot index in bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `alloc_req`, input, 1: pop the index currently shown on `alloc_idx`.
- `alloc_avail`, output, 1: a free index is presented on `alloc_idx`.
- `alloc_idx`, output, PTR_SZ: head of the free list.
- `free_req`, input, 1: push `free_idx` onto the free list.
- `free_idx`, input, PTR_SZ: index being returned.
- `ready`, output, 1: initialisation is complete.
- `free_cnt`, output, PTR_SZ+1: number of indices currently in the free list.
- `err`, output, 1: sticky protocol error flag.

## Operation
- Storage: DEPTH x PTR_SZ register array, head pointer `hd` and tail pointer `tl`, each PTR_SZ wide. Both pointers wrap from DEPTH-1 to 0; no power-of-two requirement.
- FSM has two states, INIT and RUN.
  - Reset enters INIT with an init counter of 0.
  - INIT writes mem[k] = k for k = 0..DEPTH-1, one entry per cycle, over DEPTH cycles.
  - INIT then moves to RUN with hd=0, tl=0, `free_cnt`=DEPTH and `ready`=1.
- In INIT:
  - `ready`=0, `alloc_avail`=0, `free_cnt`=0.
  - `alloc_req` and `free_req` are ignored.
  - `free_req` during INIT sets `err` when checking is compiled in.
- In RUN:
  - `alloc_avail` = (`free_cnt` != 0).
  - `alloc_idx` = mem[hd], driven combinationally from registers.
  - Pop: `alloc_req` && `alloc_avail` advances hd and decrements the count.
  - `alloc_req` while `alloc_avail`=0 is ignored and has no side effect.
  - Push: `free_req` writes mem[tl] = `free_idx`, advances tl and increments the count.
  - Push while `free_cnt`=DEPTH is dropped (overflow).
  - Simultaneous pop and push: both happen and the count is unchanged. When count=0, only the push happens; the freed index is not bypassed to `alloc_idx` in the same cycle.
- FIFO order: indices are reallocated in the order they were freed.
- Reset mid-operation: all state is cleared asynchronously, the block returns to INIT, and the free list is rebuilt as 0..DEPTH-1.

## Timing
- Reset values: `ready`=0, `alloc_avail`=0, `alloc_idx`=0, `free_cnt`=0, `err`=0.
- `ready` rises at the clock edge that ends the DEPTH-th INIT cycle, i.e. DEPTH rising edges after `rst` deasserts.
- A popped index is consumed at the edge; the next head is visible after that edge, with zero-cycle turnaround for back-to-back pops.
- A freed index becomes visible on `alloc_idx` one cycle after the push edge when the list was empty.
- `err` sets at the edge where the violation is sampled and stays set until reset.

## Configuration
- Macro `IDX_ALLOC_CHECK_EN`.
- When defined:
  - Keeps a DEPTH-bit ownership vector: bit i is set on allocation of i and cleared on free of i.
  - `err` sets on any of: `free_idx` >= DEPTH; free of an index whose bit is clear (double free); push while full; `free_req` in INIT.
  - The offending push is dropped and the list stays consistent.
- When undefined:
  - `err` is tied to 0 and no ownership vector is built.
  - Pushes are accepted unchecked, except that a push when full is still dropped.

## Test plan
- Reset then idle, DEPTH=4 -> `ready` rises after 4 edges; `free_cnt`=4, `alloc_idx`=0.
- Four back-to-back `alloc_req` -> indices 0,1,2,3 granted; `alloc_avail`=0 and `free_cnt`=0 afterwards; a fifth request is ignored.
- Free 2, then 0, into an empty list -> `alloc_idx`=2 one cycle later; the next pop yields 0.
- Simultaneous alloc+free with `free_cnt`=2 -> head advances, tail advances, `free_cnt` stays 2.
- With `IDX_ALLOC_CHECK_EN`: free 1 twice -> `err`=1 on the second free and `free_cnt` is incremented only once. Free index 5 with DEPTH=4, PTR_SZ=3 -> `err`=1.
- Assert `rst` after 3 pops -> all outputs return to reset values; after re-init `alloc_idx`=0 and `free_cnt`=4.
